// File: rtl/conv_output_requant.sv
// conv_output_requant
//   Requantizes the 48-bit accumulator stream from the convolution PE to
//   16-bit signed pixels: rounding arithmetic right shift (half toward +inf),
//   optional activation, then signed saturation. Results go through a
//   credit-protected show-ahead FIFO onto an AXI4-Stream master.
//
//   Optional feature macro: CONV_LEAKY_RELU_EN
//     defined   : act_en=1 maps negative values to r >>> 3 (leaky ReLU, slope 1/8)
//     undefined : act_en=1 maps negative values to 0 (plain ReLU)
//
// Ports
//   clk, Reset                 clock, asynchronous active-high reset
//   s_acc_data/valid/last      accumulator beat input
//   s_acc_ready                beat accepted this cycle (credit based)
//   shift_amt, act_en          quasi-static requant configuration
//   m_axis_tdata/tvalid/tlast  AXI4-Stream master output
//   m_axis_tready              downstream accept
//   overflow                   sticky: beat presented while not ready
//   idle                       pipeline and FIFO empty
module conv_output_requant #(
  parameter int RESULT_WIDTH = 48,
  parameter int OUT_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic [RESULT_WIDTH-1:0] s_acc_data,
  input  logic                    s_acc_valid,
  input  logic                    s_acc_last,
  output logic                    s_acc_ready,
  input  logic [5:0]              shift_amt,
  input  logic                    act_en,
  output logic [OUT_WIDTH-1:0]    m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    overflow,
  output logic                    idle
);

  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int CREDIT_W = CNT_W + 1;
  localparam int EXT_W    = RESULT_WIDTH + 1;

  // ---------------- stage 1: rounding shift ----------------
  logic signed [EXT_W-1:0] acc_ext, rnd, s1_next, s1_r;
  logic                    s1_valid, s1_last;
  logic                    accept;

  assign accept = s_acc_valid & s_acc_ready;

  always_comb begin
    acc_ext = {s_acc_data[RESULT_WIDTH-1], s_acc_data};
    rnd     = '0;
    if (shift_amt != 6'd0)
      rnd = EXT_W'(1) << (shift_amt - 6'd1);
    // One extra bit of headroom keeps acc + rnd from wrapping.
    s1_next = (acc_ext + rnd) >>> shift_amt;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_r     <= '0;
    end else begin
      s1_valid <= accept;
      s1_last  <= s_acc_last;
      s1_r     <= s1_next;
    end
  end

  // ---------------- stage 2: activation + saturation ----------------
  logic signed [EXT_W-1:0] act_r;
  logic [EXT_W-OUT_WIDTH:0] upper;
  logic [OUT_WIDTH-1:0]     s2_next, s2_data;
  logic                     s2_valid, s2_last;

  always_comb begin
    act_r = s1_r;
    if (act_en && s1_r[EXT_W-1]) begin
`ifdef CONV_LEAKY_RELU_EN
      act_r = s1_r >>> 3;
`else
      act_r = '0;
`endif
    end
    // Value fits when every bit from the output sign bit upward agrees.
    upper = act_r[EXT_W-1:OUT_WIDTH-1];
    if ((&upper) || !(|upper))
      s2_next = act_r[OUT_WIDTH-1:0];
    else if (act_r[EXT_W-1])
      s2_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      s2_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_data  <= s2_next;
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_WIDTH:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               wr_en, rd_en;
  logic [OUT_WIDTH:0] head;

  // Credit accounting guarantees room for every in-flight beat, so writes
  // are never refused.
  assign wr_en = s2_valid;
  assign rd_en = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {s2_last, s2_data};
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = (count != '0);
  // Gated so outputs read zero while empty (and straight out of reset).
  assign m_axis_tdata  = m_axis_tvalid ? head[OUT_WIDTH-1:0] : '0;
  assign m_axis_tlast  = m_axis_tvalid ? head[OUT_WIDTH]     : 1'b0;

  // ---------------- credit, overflow, idle ----------------
  logic [CREDIT_W-1:0] credit_used;

  assign credit_used = CREDIT_W'(count) + CREDIT_W'(s1_valid) + CREDIT_W'(s2_valid);
  assign s_acc_ready = credit_used < CREDIT_W'(FIFO_DEPTH);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      overflow <= 1'b0;
    else if (s_acc_valid && !s_acc_ready)
      overflow <= 1'b1;
  end

  assign idle = ~s1_valid & ~s2_valid & (count == '0);

endmodule

// File: tb/tb_conv_output_requant.sv
module tb_conv_output_requant;

  logic        clk = 1'b0;
  logic        Reset;
  logic [47:0] s_acc_data;
  logic        s_acc_valid;
  logic        s_acc_last;
  logic        s_acc_ready;
  logic [5:0]  shift_amt;
  logic        act_en;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        overflow;
  logic        idle;

  conv_output_requant #(
    .RESULT_WIDTH (48),
    .OUT_WIDTH    (16),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk           (clk),
    .Reset         (Reset),
    .s_acc_data    (s_acc_data),
    .s_acc_valid   (s_acc_valid),
    .s_acc_last    (s_acc_last),
    .s_acc_ready   (s_acc_ready),
    .shift_amt     (shift_amt),
    .act_en        (act_en),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // {last, data} of expected and observed output beats
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];

  bit          prev_stall;
  logic [16:0] prev_beat;
  int          stall_err;

  // Reference: plain 64-bit arithmetic of the requant rules.
  function automatic logic [15:0] model(input logic [47:0] d, input int sh, input bit act);
    longint r;
    r = longint'($signed(d));
    if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r = r >>> sh;
    if (act && r < 0) begin
`ifdef CONV_LEAKY_RELU_EN
      r = r >>> 3;
`else
      r = 0;
`endif
    end
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [47:0] rand48();
    logic [31:0] a, b;
    a = $urandom();
    b = $urandom();
    return {a[15:0], b};
  endfunction

  // One clock of stimulus; records accepted beats (via model) and output
  // handshakes, and counts tdata/tlast changes while stalled.
  task automatic step(input bit v, input logic [47:0] d, input bit l, input bit tr);
    s_acc_valid   = v;
    s_acc_data    = d;
    s_acc_last    = l;
    m_axis_tready = tr;
    @(negedge clk);
    if (prev_stall && (!m_axis_tvalid || {m_axis_tlast, m_axis_tdata} !== prev_beat))
      stall_err++;
    if (v && s_acc_ready)
      exp_q.push_back({l, model(d, int'(shift_amt), act_en)});
    if (m_axis_tvalid && tr)
      got_q.push_back({m_axis_tlast, m_axis_tdata});
    prev_stall = m_axis_tvalid && !tr;
    prev_beat  = {m_axis_tlast, m_axis_tdata};
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input bit rand_tr, output bit ok);
    for (int i = 0; i < 600; i++) begin
      if (idle && !m_axis_tvalid) break;
      step(1'b0, '0, 1'b0, rand_tr ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    ok = idle && !m_axis_tvalid;
    m_axis_tready = 1'b0;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    s_acc_valid = 1'b0; s_acc_data = '0; s_acc_last = 1'b0;
    m_axis_tready = 1'b0; shift_amt = '0; act_en = 1'b0;
    prev_stall = 1'b0; stall_err = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (s_acc_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", s_acc_ready); else passed++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); else passed++;
    checks++; if (m_axis_tdata !== 16'h0) $display("FAIL reset_tdata got=%h exp=0000", m_axis_tdata); else passed++;
    checks++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast got=%b exp=0", m_axis_tlast); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL reset_idle got=%b exp=1", idle); else passed++;
    Reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rounding();
    logic [47:0] vals [4];
    logic [15:0] req  [4];
    bit          tv   [4];
    bit ok;
    vals[0] = 48'd384; vals[1] = -48'sd384; vals[2] = 48'd127; vals[3] = 48'd0;
    req[0]  = 16'd2;   req[1]  = 16'hFFFF;  req[2]  = 16'd0;   req[3]  = 16'd0;
    clear_q();
    shift_amt = 6'd8; act_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b0, 1'b0);
      tv[i] = m_axis_tvalid;
    end
    checks++; if (tv[0] !== 1'b0 || tv[1] !== 1'b0) $display("FAIL latency_early got=%b%b exp=00", tv[0], tv[1]); else passed++;
    checks++; if (tv[2] !== 1'b1) $display("FAIL latency_3edges got=%b exp=1", tv[2]); else passed++;
    checks++; if (m_axis_tdata !== 16'd2) $display("FAIL round_head got=%h exp=0002", m_axis_tdata); else passed++;
    drain(1'b0, ok);
    checks++; if (!ok || got_q.size() != 4) $display("FAIL round_count got=%0d exp=4", got_q.size()); else passed++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i][15:0] !== req[i]) $display("FAIL round_beat%0d got=%h exp=%h", i, got_q[i][15:0], req[i]);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    bit ok;
    clear_q();
    shift_amt = 6'd0; act_en = 1'b0;
    step(1'b1, 48'h010000000000, 1'b0, 1'b0);
    step(1'b1, 48'hFF0000000000, 1'b0, 1'b0);
    drain(1'b0, ok);
    shift_amt = 6'd47;
    step(1'b1, 48'h400000000000, 1'b0, 1'b0);
    drain(1'b0, ok);
    checks++; if (!ok || got_q.size() != 3) $display("FAIL sat_count got=%0d exp=3", got_q.size());
    else begin
      passed++;
      checks++; if (got_q[0][15:0] !== 16'h7FFF) $display("FAIL sat_pos got=%h exp=7fff", got_q[0][15:0]); else passed++;
      checks++; if (got_q[1][15:0] !== 16'h8000) $display("FAIL sat_neg got=%h exp=8000", got_q[1][15:0]); else passed++;
      checks++; if (got_q[2][15:0] !== 16'h0001) $display("FAIL shift47 got=%h exp=0001", got_q[2][15:0]); else passed++;
    end
  endtask

  task automatic test_activation();
    bit ok;
    logic [15:0] neg_exp;
`ifdef CONV_LEAKY_RELU_EN
    neg_exp = 16'hFFFE;
`else
    neg_exp = 16'h0000;
`endif
    clear_q();
    shift_amt = 6'd0; act_en = 1'b1;
    step(1'b1, -48'sd16, 1'b0, 1'b0);
    step(1'b1, 48'd5, 1'b0, 1'b0);
    drain(1'b0, ok);
    act_en = 1'b0;
    checks++; if (!ok || got_q.size() != 2) $display("FAIL act_count got=%0d exp=2", got_q.size());
    else begin
      passed++;
      checks++; if (got_q[0][15:0] !== neg_exp) $display("FAIL act_neg got=%h exp=%h", got_q[0][15:0], neg_exp); else passed++;
      checks++; if (got_q[1][15:0] !== 16'd5) $display("FAIL act_pos got=%h exp=0005", got_q[1][15:0]); else passed++;
    end
  endtask

  task automatic test_random();
    bit ok;
    int err;
    for (int b = 0; b < 4; b++) begin
      clear_q();
      err = 0;
      shift_amt = 6'($urandom_range(0, 47));
      act_en    = 1'($urandom_range(0, 1));
      for (int i = 0; i < 40; i++)
        step(s_acc_ready && ($urandom_range(0, 3) != 0), rand48(), 1'b0, 1'($urandom_range(0, 1)));
      drain(1'b1, ok);
      checks++;
      if (!ok || got_q.size() != exp_q.size() || exp_q.size() == 0)
        $display("FAIL rand%0d_count got=%0d exp=%0d", b, got_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (got_q[i] !== exp_q[i]) begin
          if (err == 0) $display("FAIL rand%0d_beat%0d got=%h exp=%h", b, i, got_q[i], exp_q[i]);
          err++;
        end
      checks++; if (err != 0) $display("FAIL rand%0d_data got=%0d_bad exp=0_bad", b, err); else passed++;
    end
    act_en = 1'b0;
  endtask

  task automatic test_stream();
    bit ok;
    int idx, lasts, last_pos, err, budget;
    clear_q();
    stall_err = 0;
    shift_amt = 6'd4; act_en = 1'b0;
    idx = 0; budget = 3000;
    while (idx < 64 && budget > 0) begin
      bit v;
      v = s_acc_ready && ($urandom_range(0, 3) != 0);
      step(v, rand48(), (idx == 63), 1'($urandom_range(0, 1)));
      if (v) idx++;
      budget--;
    end
    drain(1'b1, ok);
    checks++; if (idx != 64) $display("FAIL stream_sent got=%0d exp=64", idx); else passed++;
    checks++; if (!ok || got_q.size() != 64) $display("FAIL stream_count got=%0d exp=64", got_q.size()); else passed++;
    lasts = 0; last_pos = -1; err = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i][16]) begin lasts++; last_pos = i; end
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) err++;
    end
    checks++; if (lasts != 1 || last_pos != 63) $display("FAIL stream_tlast got=%0d@%0d exp=1@63", lasts, last_pos); else passed++;
    checks++; if (err != 0) $display("FAIL stream_data got=%0d_bad exp=0_bad", err); else passed++;
    checks++; if (stall_err != 0) $display("FAIL stream_stable got=%0d_changes exp=0", stall_err); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL stream_idle got=%b exp=1", idle); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok, r;
    int accepted, err;
    clear_q();
    shift_amt = 6'd0; act_en = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_pre got=%b exp=0", overflow); else passed++;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      r = s_acc_ready;
      step(1'b1, 48'(i * 3 + 1), 1'b0, 1'b0);
      if (r) accepted++;
      if (i == 7) begin
        checks++; if (s_acc_ready !== 1'b0) $display("FAIL bp_ready_fall got=%b exp=0", s_acc_ready); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow_early got=%b exp=0", overflow); else passed++;
      end
    end
    checks++; if (accepted != 8) $display("FAIL bp_accepted got=%0d exp=8", accepted); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL bp_overflow got=%b exp=1", overflow); else passed++;
    step(1'b0, '0, 1'b0, 1'b1);
    checks++; if (s_acc_ready !== 1'b1) $display("FAIL bp_ready_rise got=%b exp=1", s_acc_ready); else passed++;
    drain(1'b0, ok);
    checks++; if (!ok || got_q.size() != 8) $display("FAIL bp_count got=%0d exp=8", got_q.size()); else passed++;
    err = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i][15:0] !== 16'(i * 3 + 1)) err++;
    checks++; if (err != 0) $display("FAIL bp_order got=%0d_bad exp=0_bad", err); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok, tv_before;
    int err;
    clear_q();
    shift_amt = 6'd2; act_en = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 48'(1000 + i * 8), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    tv_before = m_axis_tvalid;
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (tv_before !== 1'b1) $display("FAIL rmid_buffered got=%b exp=1", tv_before); else passed++;
    checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rmid_tvalid got=%b exp=0", m_axis_tvalid); else passed++;
    checks++; if (idle !== 1'b1) $display("FAIL rmid_idle got=%b exp=1", idle); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL rmid_overflow got=%b exp=0", overflow); else passed++;
    @(posedge clk);
    #1;
    Reset = 1'b0;
    prev_stall = 1'b0;
    clear_q();
    for (int i = 0; i < 4; i++) step(1'b1, 48'(40 + i * 4), (i == 3), 1'($urandom_range(0, 1)));
    drain(1'b1, ok);
    checks++; if (!ok || got_q.size() != 4) $display("FAIL rmid_count got=%0d exp=4", got_q.size()); else passed++;
    err = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== {(i == 3), 16'(10 + i)}) err++;
    checks++; if (err != 0) $display("FAIL rmid_data got=%0d_bad exp=0_bad", err); else passed++;
  endtask

  initial begin
    #3;
    test_reset();
    test_rounding();
    test_saturation();
    test_activation();
    test_random();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/conv_output_requant.md
# conv_output_requant

Downstream stage of the convolution PE. It accepts the 48-bit accumulator stream (data/valid/last) and requantizes each beat to the 16-bit pixel format with a rounding right shift, an optional activation and signed saturation. Results pass through a small credit-protected FIFO and leave on an AXI4-Stream master. It sits between the PE output and the DMA/next-layer input.

## Interface
- `RESULT_WIDTH`, 48, accumulator width.
- `OUT_WIDTH`, 16, output pixel width (signed).
- `FIFO_DEPTH`, 8, output FIFO entries; power of two, ≥4.
- `clk`  in  1  the single clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `s_acc_data`  in  RESULT_WIDTH  signed accumulator beat.
- `s_acc_valid`  in  1  beat present.
- `s_acc_last`  in  1  last beat of the output feature map.
- `s_acc_ready`  out  1  beat will be accepted this cycle.
- `shift_amt`  in  6  right-shift amount 0..47; quasi-static, changed only while `idle`=1.
- `act_en`  in  1  enables the activation; quasi-static.
- `m_axis_tdata`  out  OUT_WIDTH  requantized pixel.
- `m_axis_tvalid`  out  1  FIFO not empty.
- `m_axis_tready`  in  1  downstream accept.
- `m_axis_tlast`  out  1  tlast of the head beat.
- `overflow`  out  1  sticky: a beat was presented while `s_acc_ready`=0.
- `idle`  out  1  pipeline and FIFO empty.

## Operation
- Accept a beat on a rising edge where `s_acc_valid & s_acc_ready`.
- Stage 1 (registered): `r = (acc + (shift_amt ? 1<<(shift_amt-1) : 0)) >>> shift_amt`, computed in RESULT_WIDTH+1 bits. Rounding is half toward +inf. Carry `last` and `valid`.
- Stage 2 (registered): apply the activation (see Configuration) to `r`, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Carry `last` and `valid`.
- FIFO: write the stage-2 valid beat {data,last}. Read on `m_axis_tvalid & m_axis_tready`. Reads are show-ahead (head entry drives the outputs). A simultaneous read and write leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- Credit: `s_acc_ready = (fifo_count + s1_valid + s2_valid) < FIFO_DEPTH`. It is combinational from registers only and never depends on `s_acc_valid`. The FIFO therefore never overflows, and the pipeline never stalls once a beat is accepted.
- Drop: `s_acc_valid & ~s_acc_ready` discards the beat and sets `overflow`. `overflow` clears only on Reset.
- `idle = ~s1_valid & ~s2_valid & (fifo_count==0)`.
- AXI rule: once `m_axis_tvalid` is high, tdata/tlast hold stable until accepted.

## Timing
- Reset values: `s_acc_ready`=1, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `overflow`=0, `idle`=1. Pointers, count and stage valids are all 0.
- Latency: a beat accepted at edge E0 is in stage 1 after E0, in stage 2 after E1, and written to the FIFO at E2. `m_axis_tvalid`=1 in the cycle after E2, which is 3 edges total.
- Throughput: 1 beat/cycle while `m_axis_tready`=1.
- Full condition: with `m_axis_tready`=0, exactly FIFO_DEPTH beats are accepted. Ready falls in the cycle after the FIFO_DEPTH-th accept. It rises the cycle after the first read that frees a credit.
- Reset mid-operation: all in-flight and buffered beats are discarded immediately (asynchronous). `m_axis_tvalid` drops without handshake.

## Configuration
- `CONV_LEAKY_RELU_EN` defined: with `act_en`=1, negative `r` becomes `r >>> 3` (slope 0.125, floor) and non-negative values pass through.
- `CONV_LEAKY_RELU_EN` undefined: with `act_en`=1, negative `r` becomes 0 (plain ReLU).
- In both builds, `act_en`=0 means identity, and latency is unchanged.

## Test plan
- Rounding: shift_amt=8, act_en=0, inputs 384, -384, 127, 0 -> tdata 2, -1 (0xFFFF), 0, 0 in order. First tvalid appears 3 edges after the first accept.
- Saturation: shift_amt=0, inputs 2^40 and -2^40 -> 0x7FFF and 0x8000. shift_amt=47, input 2^46 -> 1.
- Activation: shift_amt=0, act_en=1, inputs -16 and 5 -> 0xFFFE and 5 with the macro defined; 0 and 5 without it.
- Backpressure: FIFO_DEPTH=8, tready=0, valid held for 12 cycles -> 8 beats accepted, ready low afterward, `overflow`=1. Then tready=1 -> the 8 beats emerge in order with no duplicates.
- tlast/stream: 64-beat frame with last on beat 63 and random tready -> exactly one tlast, on output beat 63, and tdata stable while stalled. `idle`=1 after the final handshake.
- Reset mid-frame: assert Reset with 5 beats buffered -> tvalid=0 and `idle`=1 immediately. A frame started after release outputs only new data.
